single_register32: RTL and testbench

A 32-bit general-purpose storage register with a write enable. It is the per-register cell of the 16-entry register bank. The bank drives a shared write-data bus to all sixteen instances and a one-hot enable vector, one bit per instance. Each instance continuously presents its stored word on its output for the bank's read multiplexing.

---
 rtl/single_register32_pkg.sv | 16 +
 rtl/dff_en.sv | 37 +++
 rtl/single_register32.sv | 49 ++++
 tb/tb_single_register32.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/single_register32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : single_register32_pkg
//  Description : Constants shared by the register bank, its write decoder and
//                the per-register storage cell.
//                  DATA_WIDTH          - word width of every bank register
//                  DEFAULT_RESET_VALUE - word loaded into a register on reset
//  Revision    : 1.0  initial release
// ============================================================================
package single_register32_pkg;

    localparam int                    DATA_WIDTH          = 32;
    localparam logic [DATA_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

endpackage : single_register32_pkg
`default_nettype wire

// File: rtl/dff_en.sv
`default_nettype none
// ============================================================================
//  Module      : dff_en
//  Description : Single-bit flip-flop with a load enable and a synchronous,
//                active-high reset to a per-instance reset value.
//  Ports       : clk - clock, state updates on the rising edge
//                rst - synchronous reset, takes priority over en
//                en  - load enable, d is captured when high
//                d   - data bit
//                q   - stored bit
//  Revision    : 1.0  initial release
// ============================================================================
module dff_en #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_BIT;
        end else if (en) begin
            r_q <= d;
        end
    end

    // Output comes straight from the flop; there is no path from d to q.
    assign q = r_q;

endmodule : dff_en
`default_nettype wire

// File: rtl/single_register32.sv
`default_nettype none
// ============================================================================
//  Module      : single_register32
//  Description : One storage cell of the 16-entry register bank. Captures the
//                shared write bus when its one-hot enable bit is set and
//                continuously presents the stored word for read muxing.
//  Ports       : clk - clock, state updates on the rising edge
//                rst - synchronous active-high reset, loads RESET_VALUE
//                en  - write enable from the bank decoder
//                Din - shared write-data bus
//                q   - stored word
//  Revision    : 1.0  initial release
// ============================================================================
module single_register32
    import single_register32_pkg::*;
#(
    parameter int               WIDTH       = DATA_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = DEFAULT_RESET_VALUE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] w_q;

    // One enabled flop per bit, each with its own reset bit so any reset
    // pattern can be produced without a separate load path.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            dff_en #(
                .RESET_BIT (RESET_VALUE[gi])
            ) u_dff (
                .clk (clk),
                .rst (rst),
                .en  (en),
                .d   (Din[gi]),
                .q   (w_q[gi])
            );
        end
    endgenerate

    assign q = w_q;

endmodule : single_register32
`default_nettype wire

// File: tb/tb_single_register32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_single_register32
//  Description : Self-checking bench for single_register32. Drives a default
//                instance and one with RESET_VALUE = 0x0000FFFF from the same
//                stimulus, compares both against a behavioural model every
//                cycle and checks hand-computed values at key points.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_single_register32;

    localparam logic [31:0] RV_A = 32'h0000_0000;
    localparam logic [31:0] RV_B = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] q_a;
    logic [31:0] q_b;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: what each register must hold, and whether a reset has
    // been seen yet (value is undefined before that).
    logic [31:0] m_a;
    logic [31:0] m_b;
    bit          m_valid = 1'b0;

    always #5 clk = ~clk;

    single_register32 u_dut_a (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .Din (Din),
        .q   (q_a)
    );

    single_register32 #(
        .WIDTH       (32),
        .RESET_VALUE (RV_B)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .Din (Din),
        .q   (q_b)
    );

    // Behavioural model: a register is "the last word written since the
    // last reset, or the reset word".
    always @(posedge clk) begin
        if (rst) begin
            m_a     = RV_A;
            m_b     = RV_B;
            m_valid = 1'b1;
        end else if (en && m_valid) begin
            m_a = Din;
            m_b = Din;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Continuous compare, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_a", q_a, m_a);
            check("model_b", q_b, m_b);
        end
    end

    task automatic cycle(input logic r, input logic e, input logic [31:0] d);
        @(negedge clk);
        rst = r;
        en  = e;
        Din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with write enable and all-ones data present.
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF);
        check("reset_a", q_a, 32'h0000_0000);
        check("reset_b", q_b, 32'h0000_FFFF);

        // Write, then change Din mid-cycle with en low.
        cycle(1'b0, 1'b1, 32'hDEAD_BEEF);
        check("write", q_a, 32'hDEAD_BEEF);
        @(negedge clk);
        en = 1'b0;
        #2 Din = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        check("no_write_mid", q_a, 32'hDEAD_BEEF);

        // Hold for 10 cycles while Din toggles.
        cycle(1'b0, 1'b1, 32'h1234_5678);
        for (int i = 0; i < 10; i++) begin
            case (i % 3)
                0:       cycle(1'b0, 1'b0, 32'h0000_0000);
                1:       cycle(1'b0, 1'b0, 32'hFFFF_FFFF);
                default: cycle(1'b0, 1'b0, 32'hA5A5_A5A5);
            endcase
            check("hold", q_a, 32'h1234_5678);
        end

        // Back-to-back writes.
        cycle(1'b0, 1'b1, 32'h0000_0001);
        check("b2b_0", q_a, 32'h0000_0001);
        cycle(1'b0, 1'b1, 32'h8000_0000);
        check("b2b_1", q_a, 32'h8000_0000);
        cycle(1'b0, 1'b1, 32'h5555_5555);
        check("b2b_2", q_b, 32'h5555_5555);

        // Reset beats a simultaneous write; next write proceeds normally.
        cycle(1'b0, 1'b1, 32'hCAFE_F00D);
        check("pre_prio", q_a, 32'hCAFE_F00D);
        cycle(1'b1, 1'b1, 32'h1111_1111);
        check("prio_a", q_a, 32'h0000_0000);
        check("prio_b", q_b, 32'h0000_FFFF);
        cycle(1'b1, 1'b0, 32'h3333_3333);
        check("reset_held_b", q_b, 32'h0000_FFFF);
        cycle(1'b0, 1'b1, 32'h2222_2222);
        check("post_reset", q_a, 32'h2222_2222);

        // Non-default reset value overwritten by zero.
        cycle(1'b1, 1'b0, 32'h7777_7777);
        check("rv_b", q_b, 32'h0000_FFFF);
        cycle(1'b0, 1'b1, 32'h0000_0000);
        check("zero_b", q_b, 32'h0000_0000);

        // Idle a couple of cycles so the compare process sees the final state.
        cycle(1'b0, 1'b0, 32'hFFFF_FFFF);
        check("final_hold", q_b, 32'h0000_0000);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_single_register32
`default_nettype wire
